// File: rtl/div_unit_pkg.sv
// Shared encodings for the EX-stage divider: FSM states, ready/start/stall levels
// and the operand magnitude helper used when a signed divide is launched.
package div_unit_pkg;

    localparam logic [1:0] DivFree   = 2'b00;
    localparam logic [1:0] DivByZero = 2'b01;
    localparam logic [1:0] DivOn     = 2'b10;
    localparam logic [1:0] DivEnd    = 2'b11;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    localparam logic DivStart = 1'b1;
    localparam logic DivStop  = 1'b0;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    localparam logic [4:0] DivLastStep = 5'd31;

    // Two's-complement magnitude; 0x80000000 maps to itself, which the
    // unsigned core then treats as 2^31.
    function automatic logic [31:0] abs_operand(input logic [31:0] value,
                                                input logic        is_signed);
        return (is_signed && value[31]) ? (~value + 32'd1) : value;
    endfunction

endpackage

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU: 32 shift-subtract steps, holds the
// pipeline via stallreq_for_div and presents {remainder, quotient} for one cycle.
module div_unit
    import div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        stallreq_for_div
);

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [64:0] work;
    logic [31:0] divisor;
    logic        is_signed;
    logic        dividend_neg;
    logic        divisor_neg;

    logic [32:0] diff;
    logic [64:0] work_step;
    logic [31:0] quot_raw;
    logic [31:0] rem_raw;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    // NOTE: every always_comb output gets an unconditional assignment on every
    // path, so no latch can be inferred.
    always_comb begin
        // work[64:32] is the partial remainder already shifted by one with the
        // next dividend bit appended, so a 33-bit borrow decides the quotient bit.
        diff = work[64:32] - {1'b0, divisor};
        if (diff[32]) begin
            work_step = {work[63:0], 1'b0};
        end else begin
            work_step = {diff[31:0], work[31:0], 1'b1};
        end
        quot_raw = work_step[31:0];
        rem_raw  = work_step[64:33];
        quot_fix = (is_signed && (dividend_neg ^ divisor_neg)) ? (~quot_raw + 32'd1) : quot_raw;
        rem_fix  = (is_signed && dividend_neg) ? (~rem_raw + 32'd1) : rem_raw;
    end

    assign stallreq_for_div = (start_i == DivStart && ready_o == DivResultNotReady) ? Stop : NoStop;

    // NOTE: the datapath registers (work, divisor, sign flags) are left out of
    // reset; they are always loaded in FREE before anything reads them.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst || annul_i) begin
            state    <= DivFree;
            cnt      <= 5'd0;
            ready_o  <= DivResultNotReady;
            result_o <= 64'd0;
        end else begin
            case (state)
                DivFree: begin
                    ready_o  <= DivResultNotReady;
                    result_o <= 64'd0;
                    if (start_i == DivStart) begin
                        if (opdata2_i == 32'd0) begin
                            state <= DivByZero;
                        end else begin
                            state        <= DivOn;
                            cnt          <= 5'd0;
                            is_signed    <= signed_div_i;
                            dividend_neg <= opdata1_i[31];
                            divisor_neg  <= opdata2_i[31];
                            divisor      <= abs_operand(opdata2_i, signed_div_i);
                            work         <= {32'd0, abs_operand(opdata1_i, signed_div_i), 1'b0};
                        end
                    end
                end
                DivByZero: begin
                    state    <= DivEnd;
                    ready_o  <= DivResultReady;
                    result_o <= 64'd0;
                end
                DivOn: begin
                    work <= work_step;
                    cnt  <= cnt + 5'd1;
                    if (cnt == DivLastStep) begin
                        state    <= DivEnd;
                        ready_o  <= DivResultReady;
                        result_o <= {rem_fix, quot_fix};
                    end
                end
                DivEnd: begin
                    state    <= DivFree;
                    ready_o  <= DivResultNotReady;
                    result_o <= 64'd0;
                end
                default: begin
                    state    <= DivFree;
                    ready_o  <= DivResultNotReady;
                    result_o <= 64'd0;
                end
            endcase
        end
    end

endmodule
